// File: rtl/cv32e40p_ft_replica_ctrl_pkg.sv
// rtl/cv32e40p_ft_replica_ctrl_pkg.sv - shared types, defaults and helpers for the TMR replica controller
package cv32e40p_pkg2_ft;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DEGRADED = 2'd1,
        PROBE    = 2'd2,
        FATAL    = 2'd3
    } ft_rctrl_state_e;

    localparam int RCTRL_INCREMENT    = 4;
    localparam int RCTRL_DECREMENT    = 1;
    localparam int RCTRL_THRESHOLD    = 16;
    localparam int RCTRL_COUNT_BIT    = 6;
    localparam int RCTRL_PROBE_DELAY  = 256;
    localparam int RCTRL_PROBE_WINDOW = 64;
    localparam int RCTRL_DLY_BIT      = 9;

    // One-hot mask of a replica index
    function automatic logic [2:0] rctrl_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Lowest-numbered set replica in a mask; 0 when empty
    function automatic logic [1:0] rctrl_first(input logic [2:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        if (mask[0]) begin
            idx = 2'd0;
        end else if (mask[1]) begin
            idx = 2'd1;
        end else if (mask[2]) begin
            idx = 2'd2;
        end
        return idx;
    endfunction

    // True when at least two replicas are set in the mask
    function automatic logic rctrl_multi(input logic [2:0] mask);
        return (mask[0] & mask[1]) | (mask[0] & mask[2]) | (mask[1] & mask[2]);
    endfunction

endpackage

// File: rtl/cv32e40p_ft_replica_ctrl_if.sv
// rtl/cv32e40p_ft_replica_ctrl_if.sv - health/exclusion signal bundle between a TMR unit and its controller
interface cv32e40p_ft_replica_ctrl_if;

    logic [2:0] block_err_i;
    logic [2:0] force_broken_i;
    logic       retest_en_i;
    logic [2:0] set_broken_o;
    logic [2:0] is_broken_o;
    logic       probing_o;
    logic [1:0] probe_idx_o;
    logic       fatal_o;
    logic [7:0] probe_fail_cnt_o;

    // Unit/debug side: supplies error flags and requests, observes exclusion
    modport master (
        output block_err_i,
        output force_broken_i,
        output retest_en_i,
        input  set_broken_o,
        input  is_broken_o,
        input  probing_o,
        input  probe_idx_o,
        input  fatal_o,
        input  probe_fail_cnt_o
    );

    // Controller side
    modport slave (
        input  block_err_i,
        input  force_broken_i,
        input  retest_en_i,
        output set_broken_o,
        output is_broken_o,
        output probing_o,
        output probe_idx_o,
        output fatal_o,
        output probe_fail_cnt_o
    );

endinterface

// File: rtl/cv32e40p_ft_replica_ctrl_health_counter.sv
// rtl/cv32e40p_ft_replica_ctrl_health_counter.sv - saturating up/down health counter for one replica
module cv32e40p_ft_health_counter
    import cv32e40p_pkg2_ft::*;
#(
    parameter int INCREMENT = RCTRL_INCREMENT,
    parameter int DECREMENT = RCTRL_DECREMENT,
    parameter int COUNT_BIT = RCTRL_COUNT_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 err,
    input  logic                 freeze,
    input  logic                 clear,
    output logic [COUNT_BIT-1:0] cnt
);

    localparam logic [COUNT_BIT:0] INC_W = (COUNT_BIT+1)'(INCREMENT);
    localparam logic [COUNT_BIT:0] DEC_W = (COUNT_BIT+1)'(DECREMENT);
    localparam logic [COUNT_BIT:0] MAX_W = {1'b0, {COUNT_BIT{1'b1}}};

    logic [COUNT_BIT:0]   wide;
    logic [COUNT_BIT:0]   sum;
    logic [COUNT_BIT:0]   diff;
    logic [COUNT_BIT-1:0] cnt_next;

    // One extra bit of headroom so both saturation ends are detected exactly
    always_comb begin
        wide     = {1'b0, cnt};
        sum      = wide + INC_W;
        diff     = wide - DEC_W;
        cnt_next = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (!freeze) begin
            if (err) begin
                cnt_next = (sum > MAX_W) ? {COUNT_BIT{1'b1}} : sum[COUNT_BIT-1:0];
            end else begin
                cnt_next = (wide < DEC_W) ? '0 : diff[COUNT_BIT-1:0];
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/cv32e40p_ft_replica_ctrl.sv
// rtl/cv32e40p_ft_replica_ctrl.sv - TMR replica health controller with exclusion and periodic re-test
module cv32e40p_ft_replica_ctrl
    import cv32e40p_pkg2_ft::*;
#(
    parameter int INCREMENT    = RCTRL_INCREMENT,
    parameter int DECREMENT    = RCTRL_DECREMENT,
    parameter int THRESHOLD    = RCTRL_THRESHOLD,
    parameter int COUNT_BIT    = RCTRL_COUNT_BIT,
    parameter int PROBE_DELAY  = RCTRL_PROBE_DELAY,
    parameter int PROBE_WINDOW = RCTRL_PROBE_WINDOW,
    parameter int DLY_BIT      = RCTRL_DLY_BIT
) (
    input  logic                     clk,
    input  logic                     rst,
    cv32e40p_ft_replica_ctrl_if.slave bus
);

    localparam logic [DLY_BIT-1:0]   DLY_LOAD = DLY_BIT'(PROBE_DELAY);
    localparam logic [DLY_BIT-1:0]   WIN_LOAD = DLY_BIT'(PROBE_WINDOW);
    localparam logic [DLY_BIT-1:0]   TMR_ONE  = DLY_BIT'(1);
    localparam logic [COUNT_BIT-1:0] THR      = COUNT_BIT'(THRESHOLD);

    ft_rctrl_state_e      state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [DLY_BIT-1:0]   tmr_q, tmr_d;
    logic [7:0]           fail_q, fail_d;
    logic [2:0]           mask_q, mask_d;

    logic [COUNT_BIT-1:0] cnt [3];
    logic [2:0]           cnt_trip;
    logic [2:0]           trip;
    logic [2:0]           idx_oh;
    logic [2:0]           other;
    logic [2:0]           freeze;
    logic [2:0]           clear;
    logic                 clear_idx;

    for (genvar k = 0; k < 3; k++) begin : g_cnt
        cv32e40p_ft_health_counter #(
            .INCREMENT (INCREMENT),
            .DECREMENT (DECREMENT),
            .COUNT_BIT (COUNT_BIT)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .err    (bus.block_err_i[k]),
            .freeze (freeze[k]),
            .clear  (clear[k]),
            .cnt    (cnt[k])
        );
        assign cnt_trip[k] = (cnt[k] >= THR);
    end

    // Trip is taken from the registered counters, so it acts one cycle after the update
    always_comb begin
        idx_oh = rctrl_onehot(idx_q);
        trip   = cnt_trip | bus.force_broken_i;
        other  = trip & ~idx_oh;
        freeze = ({3{state_q == DEGRADED}} & idx_oh) | ({3{state_q == FATAL}} & mask_q);
        clear  = {3{clear_idx}} & idx_oh;
    end

    // Next-state and datapath updates; one timer serves both delay and window
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmr_d     = tmr_q;
        fail_d    = fail_q;
        mask_d    = mask_q;
        clear_idx = 1'b0;
        case (state_q)
            NORMAL: begin
                if (rctrl_multi(trip)) begin
                    state_d = FATAL;
                    mask_d  = trip;
                end else if (|trip) begin
                    state_d = DEGRADED;
                    idx_d   = rctrl_first(trip);
                    tmr_d   = DLY_LOAD;
                end
            end
            DEGRADED: begin
                if (|other) begin
                    state_d = FATAL;
                    mask_d  = other | idx_oh;
                end else if (bus.retest_en_i && !bus.force_broken_i[idx_q]) begin
                    if (tmr_q <= TMR_ONE) begin
                        state_d   = PROBE;
                        tmr_d     = WIN_LOAD;
                        clear_idx = 1'b1;
                    end else begin
                        tmr_d = tmr_q - TMR_ONE;
                    end
                end else begin
                    tmr_d = DLY_LOAD;
                end
            end
            PROBE: begin
                if (|other) begin
                    state_d = FATAL;
                    mask_d  = other | idx_oh;
                end else if (bus.block_err_i[idx_q] || bus.force_broken_i[idx_q]) begin
                    state_d = DEGRADED;
                    tmr_d   = DLY_LOAD;
                    if (fail_q != 8'hFF) begin
                        fail_d = fail_q + 8'd1;
                    end
                end else if (tmr_q <= TMR_ONE) begin
                    state_d   = NORMAL;
                    idx_d     = 2'd0;
                    clear_idx = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            FATAL: begin
                mask_d = mask_q | trip;
            end
            default: begin
                state_d = FATAL;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
            idx_q   <= 2'd0;
            tmr_q   <= '0;
            fail_q  <= 8'd0;
            mask_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            fail_q  <= fail_d;
            mask_q  <= mask_d;
        end
    end

    // Exclusion outputs decoded from the registered state
    always_comb begin
        bus.set_broken_o     = 3'b000;
        bus.is_broken_o      = 3'b000;
        bus.probing_o        = 1'b0;
        bus.fatal_o          = 1'b0;
        bus.probe_idx_o      = idx_q;
        bus.probe_fail_cnt_o = fail_q;
        case (state_q)
            DEGRADED: begin
                bus.set_broken_o = idx_oh;
                bus.is_broken_o  = idx_oh;
            end
            PROBE: begin
                bus.probing_o = 1'b1;
            end
            FATAL: begin
                bus.fatal_o      = 1'b1;
                bus.set_broken_o = mask_q;
                bus.is_broken_o  = mask_q;
            end
            default: begin
            end
        endcase
    end

endmodule
